// File: rtl/alu_pkg.sv
// Shared definitions for the 9-bit ALU datapath and its companion divider.
// Contents: ALU select codes, the datapath width, and the divider FSM state type.
package alu_pkg;

    // ALU select codes; DIV occupies the code left free by the combinational ALU.
    localparam logic [1:0] SUB  = 2'b00;
    localparam logic [1:0] ADD  = 2'b01;
    localparam logic [1:0] MULT = 2'b10;
    localparam logic [1:0] DIV  = 2'b11;

    localparam int unsigned DATA_W = 9;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, then subtract the divisor if it fits and record a quotient 1.
// Ports:
//   r        partial remainder in (WIDTH+1 bits)
//   q        quotient/dividend shift register in
//   divisor  captured divisor
//   r_next   partial remainder out
//   q_next   shift register out
module div_step #(
    parameter int unsigned WIDTH = 9
) (
    input  logic [WIDTH:0]   r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] dvsr_ext;
    // The remainder stays below the divisor between iterations, so its MSB is always 0
    // and is shifted out.
    logic           unused_r_msb;

    assign unused_r_msb = r[WIDTH];

    always_comb begin
        shifted  = {r[WIDTH-1:0], q[WIDTH-1]};
        dvsr_ext = {1'b0, divisor};
        q_next   = {q[WIDTH-2:0], 1'b0};
        r_next   = shifted;
        if (shifted >= dvsr_ext) begin
            r_next    = shifted - dvsr_ext;
            q_next[0] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_div.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   request strobe, accepted in IDLE or DONE
//   dividend, divisor       operands, captured on acceptance
//   busy                    high while iterating
//   done                    one-cycle completion pulse
//   quotient, remainder     results, held until the next result is produced
//   div_by_zero             set with done when the captured divisor was 0
import alu_pkg::*;

module alu_div #(
    parameter int unsigned WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned     CntW     = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastIter = CntW'(WIDTH - 1);

    div_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]  r_q, r_d, r_step;
    logic [WIDTH-1:0] q_q, q_d, q_step;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r      (r_q),
        .q      (q_q),
        .divisor(dvsr_q),
        .r_next (r_step),
        .q_next (q_step)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next state and datapath. Results are only written on the edge entering DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dvsr_d = divisor;
                    q_d    = dividend;
                    r_d    = '0;
                    cnt_d  = '0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIter) begin
                    state_d = DONE;
                    quot_d  = q_step;
                    rem_d   = r_step[WIDTH-1:0];
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are decoded from registered state only.
    always_comb begin
        busy        = (state_q == RUN);
        done        = (state_q == DONE);
        quotient    = quot_q;
        remainder   = rem_q;
        div_by_zero = dbz_q;
    end

endmodule

// File: tb/tb_alu_div.sv
module tb_alu_div;

    localparam int W = 9;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    alu_div #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division.
    function automatic void ref_div(input int a, input int b, output int q, output int r,
                                    output bit z);
        if (b == 0) begin
            q = 511; r = a; z = 1'b1;
        end else begin
            q = a / b; r = a % b; z = 1'b0;
        end
    endfunction

    // Issue one operation from a post-edge time point and wait until done is seen.
    // Returns edges from acceptance to the done cycle and count of busy cycles before it.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int edges, output int busy_cyc);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
        edges = 1; busy_cyc = 0;
        while (done !== 1'b1 && edges < 40) begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d z=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] a_tab [4] = '{100, 511, 5, 0};
        logic [W-1:0] b_tab [4] = '{7, 1, 9, 3};
        int edges, bc, eq, er;
        bit ez;
        for (int i = 0; i < 4; i++) begin
            do_div(a_tab[i], b_tab[i], edges, bc);
            ref_div(int'(a_tab[i]), int'(b_tab[i]), eq, er, ez);
            n_checks++;
            if (edges != 10 || bc != 9 || busy !== 1'b0) begin
                n_errors++;
                $display("FAIL dir_timing %0d/%0d: got edges=%0d busy_cycles=%0d busy=%b, want 10 9 0",
                         a_tab[i], b_tab[i], edges, bc, busy);
            end
            n_checks++;
            if (quotient !== W'(eq) || remainder !== W'(er) || div_by_zero !== ez) begin
                n_errors++;
                $display("FAIL dir_result %0d/%0d: got q=%0d r=%0d z=%b, want q=%0d r=%0d z=%b",
                         a_tab[i], b_tab[i], quotient, remainder, div_by_zero, eq, er, ez);
            end
            @(posedge clk); #1;
            n_checks++;
            if (done !== 1'b0 || quotient !== W'(eq) || remainder !== W'(er)) begin
                n_errors++;
                $display("FAIL dir_hold %0d/%0d: got done=%b q=%0d r=%0d, want done=0 q=%0d r=%0d",
                         a_tab[i], b_tab[i], done, quotient, remainder, eq, er);
            end
        end
    endtask

    task automatic test_div_zero();
        int edges, bc;
        do_div(9'd37, 9'd0, edges, bc);
        n_checks++;
        if (edges != 1 || bc != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL dbz_timing: got edges=%0d busy_cycles=%0d busy=%b, want 1 0 0",
                     edges, bc, busy);
        end
        n_checks++;
        if (quotient !== 9'd511 || remainder !== 9'd37 || div_by_zero !== 1'b1) begin
            n_errors++;
            $display("FAIL dbz_result: got q=%0d r=%0d z=%b, want q=511 r=37 z=1",
                     quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        int edges;
        start = 1'b1; dividend = 9'd200; divisor = 9'd13;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        repeat (3) begin @(posedge clk); #1; edges++; end
        start = 1'b1; dividend = 9'd50; divisor = 9'd5;
        @(posedge clk); #1; edges++;
        start = 1'b0;
        while (done !== 1'b1 && edges < 40) begin @(posedge clk); #1; edges++; end
        n_checks++;
        if (edges != 10 || quotient !== 9'd15 || remainder !== 9'd5 || div_by_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL ignore_start: got edges=%0d q=%0d r=%0d z=%b, want 10 q=15 r=5 z=0",
                     edges, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int edges, bc;
        bit held_ok;
        do_div(9'd350, 9'd7, edges, bc);
        n_checks++;
        if (done !== 1'b1 || quotient !== 9'd50 || remainder !== 9'd0) begin
            n_errors++;
            $display("FAIL b2b_first: got done=%b q=%0d r=%0d, want done=1 q=50 r=0",
                     done, quotient, remainder);
        end
        // Issue during the DONE cycle.
        start = 1'b1; dividend = 9'd300; divisor = 9'd17;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1; held_ok = 1'b1;
        while (done !== 1'b1 && edges < 40) begin
            if (busy !== 1'b1 || quotient !== 9'd50 || remainder !== 9'd0) held_ok = 1'b0;
            @(posedge clk); #1; edges++;
        end
        n_checks++;
        if (!held_ok) begin
            n_errors++;
            $display("FAIL b2b_hold: got busy/results changed during second run, want busy=1 q=50 r=0");
        end
        n_checks++;
        if (edges != 10 || quotient !== 9'd17 || remainder !== 9'd11) begin
            n_errors++;
            $display("FAIL b2b_second: got edges=%0d q=%0d r=%0d, want 10 q=17 r=11",
                     edges, quotient, remainder);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int edges, bc;
        bit saw_done;
        start = 1'b1; dividend = 9'd100; divisor = 9'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            n_errors++;
            $display("FAIL abort_outputs: got busy=%b done=%b q=%0d r=%0d z=%b, want all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done) begin
            n_errors++;
            $display("FAIL abort_no_done: got busy/done after aborted op, want both 0");
        end
        do_div(9'd9, 9'd3, edges, bc);
        n_checks++;
        if (edges != 10 || quotient !== 9'd3 || remainder !== 9'd0 || div_by_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_next: got edges=%0d q=%0d r=%0d z=%b, want 10 q=3 r=0 z=0",
                     edges, quotient, remainder, div_by_zero);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int edges, bc, eq, er, want_edges;
        bit ez;
        logic [W-1:0] a, b;
        int bad_res = 0, bad_inv = 0, bad_tim = 0;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom);
            b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
            do_div(a, b, edges, bc);
            ref_div(int'(a), int'(b), eq, er, ez);
            want_edges = ez ? 1 : 10;
            n_checks++;
            if (quotient !== W'(eq) || remainder !== W'(er) || div_by_zero !== ez) begin
                n_errors++;
                if (bad_res++ < 5)
                    $display("FAIL rand_result %0d/%0d: got q=%0d r=%0d z=%b, want q=%0d r=%0d z=%b",
                             a, b, quotient, remainder, div_by_zero, eq, er, ez);
            end
            n_checks++;
            if (edges != want_edges || busy !== 1'b0) begin
                n_errors++;
                if (bad_tim++ < 5)
                    $display("FAIL rand_timing %0d/%0d: got edges=%0d busy=%b, want %0d 0",
                             a, b, edges, busy, want_edges);
            end
            if (b != 0) begin
                n_checks++;
                if (int'(quotient) * int'(b) + int'(remainder) != int'(a) || remainder >= b) begin
                    n_errors++;
                    if (bad_inv++ < 5)
                        $display("FAIL rand_invariant %0d/%0d: got q=%0d r=%0d, want q*b+r=a, r<b",
                                 a, b, quotient, remainder);
                end
            end
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_directed();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
